// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with memory wait states.
// Optional jump instruction compiled in when the JUMP_EN macro is defined.
module multicycle_control #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned OP_W  = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OP_W-1:0] OP_LW    = 6'd35;
    localparam logic [OP_W-1:0] OP_SW    = 6'd43;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
`ifdef JUMP_EN
    localparam logic [OP_W-1:0] OP_J     = 6'd2;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
`ifdef JUMP_EN
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
`else
        S_ADDIWB = 4'd10
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             w_mem_state;
    logic             w_last_wait;

    // Memory-facing states are stretched by the wait counter.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_last_wait = (r_wait_cnt >= CNT_W'(MEM_WAIT));

    assign w_wait_cnt_next = (w_mem_state && !w_last_wait) ? r_wait_cnt + CNT_W'(1)
                                                           : CNT_W'(0);

    assign state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= CNT_W'(0);
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Moore outputs from state/counter; DECODE additionally looks at opcode.
    always_comb begin
        w_next_state = S_FETCH;
        PCWrite      = 1'b0;
        Branch       = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSrc        = 2'b00;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (w_last_wait) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
`ifdef JUMP_EN
                    OP_J:         w_next_state = S_JUMP;
`endif
                    default: begin
                        illegal_op   = 1'b1;
                        instr_done   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead      = 1'b1;
                IorD         = 1'b1;
                w_next_state = w_last_wait ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (w_last_wait) begin
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_MEMWR;
                end
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
`ifdef JUMP_EN
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
            end
`endif
            default: w_next_state = S_FETCH;
        endcase
    end

    mem_excl_a: assert property (@(posedge clk) disable iff (!rst_n) !(MemRead && MemWrite));
`ifndef JUMP_EN
    no_jump_pcsrc_a: assert property (@(posedge clk) disable iff (!rst_n) PCSrc != 2'b10);
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle MIPS control decoder. A Moore FSM sequences each instruction over several clock cycles: fetch, decode, execute, memory and writeback. It drives the shared-ALU / single-memory datapath. A parameterised wait-state counter stretches every memory access, and an optional jump instruction can be compiled in.

## Interface
Parameters:
- MEM_WAIT, 0, extra wait cycles per memory access (0..15); memory control held for MEM_WAIT+1 cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load (PC loads if ALU zero).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register: 0 = rt, 1 = rd.
- MemtoReg  out  1  write data: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state encoding (debug).

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Codes 12-15 are unreachable and recover to FETCH.
- Every output not listed for a state is 0. No X values are driven.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=1 and PCWrite=1 only in the last wait cycle.
- DECODE: ALUSrcB=11. Next state by opcode:
  - 0 → EXEC; 35/43 → MEMADR; 4 → BRANCH; 8 → ADDIEX; 2 → JUMP (when enabled).
  - Any other opcode: illegal_op=1, instr_done=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Opcode 35 → MEMRD; otherwise → MEMWR.
- MEMRD: MemRead=1, IorD=1 for MEM_WAIT+1 cycles, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWR: MemWrite=1, IorD=1 for MEM_WAIT+1 cycles. instr_done in the last cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- ALUWB: RegWrite=1, RegDst=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
- ADDIEX: ALUSrcA=1, ALUSrcB=10.
- ADDIWB: RegWrite=1.
- JUMP: PCWrite=1, PCSrc=10.
- MEMWB, ALUWB, BRANCH, ADDIWB and JUMP each last one cycle, assert instr_done, and return to FETCH.
- Wait counter:
  - Width 4, reset 0.
  - Increments each cycle in FETCH, MEMRD and MEMWR while below MEM_WAIT.
  - Cleared on leaving those states.
  - With MEM_WAIT=0 each memory state lasts exactly one cycle.

## Timing
- State register and counter update on the rising edge of clk.
- Outputs are combinational from state and counter. Exception: illegal_op and the DECODE next-state logic also depend on opcode.
- Reset (rst_n low) asynchronously forces state=FETCH, counter=0, with immediate effect.
- While in reset, outputs therefore show FETCH values: MemRead=1; IRWrite=PCWrite=1 only if MEM_WAIT=0; all others 0. Datapath registers are held in reset concurrently.
- Deasserting rst_n mid-instruction restarts at FETCH. No partial write completes after reset.
- Cycles per instruction, with W=MEM_WAIT:
  - R-type: 4+W; lw: 5+2W; sw: 4+2W.
  - beq: 3+W; addi: 4+W; j: 3+W; illegal: 2+W.
- Opcode must be stable from the DECODE cycle until instr_done.

## Configuration
- JUMP_EN defined: opcode 2 → JUMP state.
- JUMP_EN undefined:
  - The JUMP state is not built.
  - Opcode 2 is treated as illegal.
  - PCSrc never takes the value 10.

## Test plan
- Reset with MEM_WAIT=0, release, opcode=0 → state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_done high exactly 1 cycle.
- MEM_WAIT=2, opcode=35 → FETCH 3 cycles (IRWrite only in 3rd), MEMRD 3 cycles, MEMWB asserts MemtoReg=1 and RegWrite=1; total 9 cycles.
- MEM_WAIT=1, opcode=43 → MemWrite=1 with IorD=1 for exactly 2 cycles, no RegWrite; instr_done on the 2nd MEMWR cycle; total 6 cycles.
- opcode=4 then opcode=8 back-to-back → BRANCH has Branch=1, ALUOp=01, PCSrc=01; ADDIEX→ADDIWB with RegWrite=1, RegDst=0, MemtoReg=0.
- opcode=2:
  - With JUMP_EN: JUMP asserts PCWrite=1, PCSrc=10.
  - Without JUMP_EN: illegal_op=1 for one cycle in DECODE, then FETCH with no writes.
  - opcode=63 gives the illegal response in both builds.
- rst_n pulled low during MEMWR → state=0 asynchronously, MemWrite drops at once, counter=0. After release, fetch restarts cleanly.
